// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. It is a circular FIFO of
// (instruction, PC) pairs with first-word-fall-through head outputs and a flush.
module inst_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              we_if_i,
  input  logic [31:0]       inst_if_i,
  input  logic [31:0]       pc_if_i,
  output logic              full_if_o,
  output logic              afull_if_o,
  input  logic              re_id_i,
  output logic [31:0]       inst_id_o,
  output logic [31:0]       pc_id_o,
  output logic              empty_id_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic              wr_en;
  logic              rd_en;

  // Full and empty come from the occupancy count alone, because the pointers
  // are equal in both cases.
  assign empty_id_o = (count == '0);
  assign full_if_o  = (count == FULL_LVL);
  assign afull_if_o = (count >= AFULL_LVL);
  assign count_o    = count;

  assign inst_id_o = empty_id_o ? 32'h0 : inst_mem[head];
  assign pc_id_o   = empty_id_o ? 32'h0 : pc_mem[head];

  assign wr_en = we_if_i && !full_if_o && !flush_i;
  assign rd_en = re_id_i && !empty_id_o && !flush_i;

  // NOTE: the storage arrays are deliberately left out of reset. Stale entries
  // cannot be seen because the head outputs are masked whenever the count is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[tail] <= inst_if_i;
      pc_mem[tail]   <= pc_if_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. This way every
  // process sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode/issue stage. It buffers fetched (instruction, PC) pairs in a circular FIFO and presents the oldest pair first-word-fall-through, so decode can inspect it and pop it with a combinational read enable. A flush drops every buffered entry on branch mispredict or redirect.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_W, 4, log2(DEPTH)
- AFULL_MARGIN, 2, almost-full asserts when free slots ≤ this value; range 0..DEPTH-1

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush_i  input  1  discard all entries (mispredict/redirect)
- we_if_i  input  1  fetch write request
- inst_if_i  input  32  instruction to enqueue
- pc_if_i  input  32  PC of that instruction
- full_if_o  output  1  queue full; fetch must not expect a write to be accepted
- afull_if_o  output  1  almost full; fetch stops issuing new memory requests
- re_id_i  input  1  decode pop request
- inst_id_o  output  32  head instruction; 0 when empty
- pc_id_o  output  32  head PC; 0 when empty
- empty_id_o  output  1  queue empty
- count_o  output  ADDR_W+1  current occupancy, 0..DEPTH

## Operation
- State:
  - storage arrays inst_mem[DEPTH] and pc_mem[DEPTH], not reset
  - head and tail pointers, ADDR_W bits each
  - count register, ADDR_W+1 bits
- Flags, combinational from count:
  - empty_id_o = (count == 0)
  - full_if_o = (count == DEPTH)
  - afull_if_o = (count ≥ DEPTH − AFULL_MARGIN)
- Head outputs: inst_id_o = inst_mem[head] and pc_id_o = pc_mem[head] when not empty; both forced to 0 when empty.
- Accepted write: we_if_i && !full_if_o && !flush_i.
  - Stores inst_if_i/pc_if_i at tail.
  - Advances tail by 1 modulo DEPTH.
- Accepted pop: re_id_i && !empty_id_o && !flush_i.
  - Advances head by 1 modulo DEPTH.
- Count update:
  - +1 on write only
  - −1 on pop only
  - unchanged when both or neither occur
- Full with simultaneous pop: the write is still rejected. full_if_o is not bypassed by re_id_i.
- Empty with simultaneous write: no bypass. The entry becomes visible the next cycle.
- Rejected operations:
  - re_id_i while empty: no state change.
  - we_if_i while full: data dropped, no state change. Fetch is responsible for holding it.
- Flush:
  - head = tail = count = 0.
  - Overrides any concurrent write and pop; both are dropped.
- Reset (rst = 1 at an edge):
  - Same pointer/count effect as flush; has priority over flush, writes and pops.
  - Resulting outputs: empty_id_o = 1, full_if_o = 0, afull_if_o = 0 (when AFULL_MARGIN < DEPTH), count_o = 0, inst_id_o = 0, pc_id_o = 0.
  - Reset mid-operation discards all entries exactly like flush.
- Pointer wrap: natural ADDR_W-bit overflow. Full and empty are distinguished only by count, never by pointer equality.

## Timing
- Write-to-visible latency: 1 cycle. A pair written at edge N appears on inst_id_o/pc_id_o after edge N (cycle N+1) if the queue was empty.
- Pop: decode samples the head outputs and raises re_id_i in the same cycle. The next entry appears after the edge.
- Back-to-back pops: sustain 1 entry/cycle while count ≥ 1.
- All outputs are functions of registered state only. No combinational path from any input to any output.
- Flags update one edge after the causing event.
- Flush: takes effect at the edge where flush_i = 1. The next cycle shows empty_id_o = 1.
- A write in the cycle after a flush is accepted normally.

## Test plan
- Reset then idle:
  - Stimulus: rst for 2 cycles, then release.
  - Required: empty_id_o = 1, count_o = 0, inst_id_o = 0, pc_id_o = 0, full_if_o = 0.
- Fill and drain (DEPTH = 16):
  - Stimulus: write inst = 0x00000013 + i, pc = 0x1000 + 4i for i = 0..15; the 17th write is attempted.
  - Required: full_if_o = 1 after the 16th write; the 17th is dropped.
  - Required: afull_if_o rises at count = 14.
  - Stimulus: pop 16 times.
  - Required: outputs appear in order (0x13, 0x1000) … (0x22, 0x103C), then empty_id_o = 1.
- Simultaneous read/write with wrap:
  - Stimulus: hold count = 3 with head at entry 14, then write and pop every cycle for 20 cycles.
  - Required: count_o stays 3 and FIFO order is preserved across the pointer wrap.
- Empty edge cases:
  - Stimulus: re_id_i = 1 while empty.
  - Required: no change.
  - Stimulus: write 0xDEADBEEF/0x2000 while empty with re_id_i = 1.
  - Required: the entry appears the next cycle and is not popped.
- Full with pop:
  - Stimulus: at count = 16, assert we_if_i and re_id_i together.
  - Required: the pop is accepted, the write is dropped, count_o = 15.
- Flush/reset mid-stream:
  - Stimulus: at count = 5, assert flush_i together with we_if_i and re_id_i.
  - Required: next cycle count_o = 0, empty_id_o = 1; the flushed write never appears.
  - Stimulus: repeat the sequence with rst instead of flush_i.
  - Required: identical result.
